ibex_lsu_resp: RTL

Load/store responder that executes the data-memory requests issued by the ID/EX stage and returns load data, error status and the last address. It sits between the ID-stage LSU handshake and the core data bus. It splits misaligned accesses into two aligned bus transactions and performs byte-lane steering and sign extension.

---
 rtl/ibex_pkg.sv | 20 ++
 rtl/ibex_lsu_resp_if.sv | 24 ++
 rtl/ibex_lsu_align.sv | 64 ++++++
 rtl/ibex_lsu_resp.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared types for the LSU responder.
// Contents: load/store size encodings and the responder FSM state enum.
package ibex_pkg;

    // Access size as presented on lsu_type_i (2'b11 also decodes as byte).
    localparam logic [1:0] LSU_WORD = 2'b00;
    localparam logic [1:0] LSU_HALF = 2'b01;
    localparam logic [1:0] LSU_BYTE = 2'b10;

    // *_MIS states carry the first half of a split access; WAIT_GNT/WAIT_RVALID
    // serve both single accesses and the second half of a split one.
    typedef enum logic [2:0] {
        IDLE,
        WAIT_GNT_MIS,
        WAIT_RVALID_MIS,
        WAIT_GNT,
        WAIT_RVALID
    } ls_fsm_e;

endpackage

// File: rtl/ibex_lsu_resp_if.sv
// Core data-bus bundle between the LSU responder (master) and memory (slave).
// Signals: req/gnt handshake, rvalid/err response, word-aligned addr, we,
// byte enables, lane-steered write data and read data.
interface ibex_lsu_resp_if;
    logic        req;
    logic        gnt;
    logic        rvalid;
    logic        err;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, err, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, err, rdata
    );
endinterface

// File: rtl/ibex_lsu_align.sv
// Purely combinational lane logic for the LSU responder.
// Inputs : access type/offset/sign-extension, second-half flag, raw store data,
//          latched first-half read data and live bus read data.
// Outputs: split_o (access needs two bus transactions), be_o, rotated wdata_o,
//          merged and extended rdata_o.
module ibex_lsu_align
    import ibex_pkg::*;
(
    input  logic [1:0]  type_i,
    input  logic [1:0]  off_i,
    input  logic        sign_ext_i,
    input  logic        second_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_first_i,
    input  logic [31:0] rdata_i,
    output logic        split_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);
    logic [3:0]  be_base;
    logic [7:0]  be_wide;
    logic [4:0]  shamt;
    logic [63:0] wdata_dup;
    logic [63:0] rdata_cat;
    logic [63:0] rdata_cat_sh;
    logic [31:0] rdata_sh;

    assign shamt   = {off_i, 3'b000};
    assign split_o = ((type_i == LSU_WORD) && (off_i != 2'd0)) ||
                     ((type_i == LSU_HALF) && (off_i == 2'd3));

    always_comb begin
        be_base = 4'b0001;
        case (type_i)
            LSU_WORD: be_base = 4'b1111;
            LSU_HALF: be_base = 4'b0011;
            default:  be_base = 4'b0001;
        endcase
    end

    // Shifting into an 8-bit window yields both halves at once: the low nibble
    // is the first word's enables, the high nibble what spills into the next.
    assign be_wide = {4'b0000, be_base} << off_i;
    assign be_o    = second_i ? be_wide[7:4] : be_wide[3:0];

    // Rotate-left by the byte offset; the same word serves both halves.
    assign wdata_dup = {wdata_i, wdata_i} << shamt;
    assign wdata_o   = wdata_dup[63:32];

    assign rdata_cat    = second_i ? {rdata_i, rdata_first_i} : {32'd0, rdata_i};
    assign rdata_cat_sh = rdata_cat >> shamt;
    assign rdata_sh     = rdata_cat_sh[31:0];

    always_comb begin
        rdata_o = rdata_sh;
        case (type_i)
            LSU_WORD: rdata_o = rdata_sh;
            LSU_HALF: rdata_o = {{16{sign_ext_i & rdata_sh[15]}}, rdata_sh[15:0]};
            default:  rdata_o = {{24{sign_ext_i & rdata_sh[7]}}, rdata_sh[7:0]};
        endcase
    end

endmodule

// File: rtl/ibex_lsu_resp.sv
// LSU responder: executes one load/store from the ID stage on the data bus,
// splitting misaligned accesses into two aligned transactions.
// Ports: clk_i/rst_ni (sync, active-low); lsu_* request side from ID
// (req/we/type/sign_ext/wdata/address in; valid/rdata/errors/incr_req/addr_last
// out); busy_o; data_bus master modport toward memory.
module ibex_lsu_resp
    import ibex_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   lsu_req_i,
    input  logic                   lsu_we_i,
    input  logic [1:0]             lsu_type_i,
    input  logic                   lsu_sign_ext_i,
    input  logic [31:0]            lsu_wdata_i,
    input  logic [31:0]            adder_result_ex_i,
    output logic                   lsu_valid_o,
    output logic [31:0]            lsu_rdata_o,
    output logic                   lsu_load_err_o,
    output logic                   lsu_store_err_o,
    output logic                   lsu_addr_incr_req_o,
    output logic [31:0]            lsu_addr_last_o,
    output logic                   busy_o,
    ibex_lsu_resp_if.master        data_bus
);
    ls_fsm_e     state_q, state_d;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  type_q;
    logic        we_q, sign_ext_q;
    logic [31:0] rdata_first_q, rdata_first_d;
    logic [31:0] addr_last_q, addr_last_d;
    logic        err_q, err_d;
    logic        second_q, second_d;

    logic        idle, capture, req, valid, err_out;
    logic [31:0] cur_addr, cur_wdata, addr_aligned, bus_addr;
    logic [1:0]  cur_type;
    logic        cur_we, cur_sign_ext;
    logic        split;
    logic [3:0]  be;
    logic [31:0] wdata_rot, rdata_ext;

    // In IDLE the live request drives the bus; afterwards only latched fields.
    assign idle         = (state_q == IDLE);
    assign cur_addr     = idle ? adder_result_ex_i : addr_q;
    assign cur_wdata    = idle ? lsu_wdata_i       : wdata_q;
    assign cur_type     = idle ? lsu_type_i        : type_q;
    assign cur_we       = idle ? lsu_we_i          : we_q;
    assign cur_sign_ext = idle ? lsu_sign_ext_i    : sign_ext_q;
    assign addr_aligned = {cur_addr[31:2], 2'b00};
    assign bus_addr     = second_q ? addr_aligned + 32'd4 : addr_aligned;

    ibex_lsu_align u_align (
        .type_i        (cur_type),
        .off_i         (cur_addr[1:0]),
        .sign_ext_i    (cur_sign_ext),
        .second_i      (second_q),
        .wdata_i       (cur_wdata),
        .rdata_first_i (rdata_first_q),
        .rdata_i       (data_bus.rdata),
        .split_o       (split),
        .be_o          (be),
        .wdata_o       (wdata_rot),
        .rdata_o       (rdata_ext)
    );

    always_comb begin
        state_d       = state_q;
        err_d         = err_q;
        second_d      = second_q;
        rdata_first_d = rdata_first_q;
        addr_last_d   = addr_last_q;
        capture       = 1'b0;
        req           = 1'b0;
        valid         = 1'b0;
        err_out       = 1'b0;

        case (state_q)
            IDLE: begin
                req = lsu_req_i;
                if (lsu_req_i) begin
                    capture = 1'b1;
                    if (data_bus.gnt) begin
                        addr_last_d = adder_result_ex_i;
                        state_d     = split ? WAIT_RVALID_MIS : WAIT_RVALID;
                    end else begin
                        state_d     = split ? WAIT_GNT_MIS : WAIT_GNT;
                    end
                end
            end
            WAIT_GNT_MIS: begin
                req = 1'b1;
                if (data_bus.gnt) begin
                    addr_last_d = addr_q;
                    state_d     = WAIT_RVALID_MIS;
                end
            end
            WAIT_RVALID_MIS: begin
                if (data_bus.rvalid) begin
                    rdata_first_d = data_bus.rdata;
                    err_d         = err_q | data_bus.err;
                    second_d      = 1'b1;
                    state_d       = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                req = 1'b1;
                if (data_bus.gnt) begin
                    addr_last_d = second_q ? bus_addr : addr_q;
                    state_d     = WAIT_RVALID;
                end
            end
            WAIT_RVALID: begin
                if (data_bus.rvalid) begin
                    valid    = 1'b1;
                    err_out  = err_q | data_bus.err;
                    err_d    = 1'b0;
                    second_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // While reset is asserted nothing may leak onto the bus or to ID.
        if (!rst_ni) begin
            req     = 1'b0;
            valid   = 1'b0;
            err_out = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            type_q        <= '0;
            we_q          <= 1'b0;
            sign_ext_q    <= 1'b0;
            rdata_first_q <= '0;
            addr_last_q   <= '0;
            err_q         <= 1'b0;
            second_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            rdata_first_q <= rdata_first_d;
            addr_last_q   <= addr_last_d;
            err_q         <= err_d;
            second_q      <= second_d;
            if (capture) begin
                addr_q     <= adder_result_ex_i;
                wdata_q    <= lsu_wdata_i;
                type_q     <= lsu_type_i;
                we_q       <= lsu_we_i;
                sign_ext_q <= lsu_sign_ext_i;
            end
        end
    end

    // Bus payload is zeroed whenever no request is presented.
    assign data_bus.req   = req;
    assign data_bus.addr  = req ? bus_addr  : '0;
    assign data_bus.we    = req & cur_we;
    assign data_bus.be    = req ? be        : '0;
    assign data_bus.wdata = req ? wdata_rot : '0;

    assign lsu_valid_o         = valid;
    assign lsu_rdata_o         = valid ? rdata_ext : '0;
    assign lsu_load_err_o      = valid & err_out & ~we_q;
    assign lsu_store_err_o     = valid & err_out & we_q;
    assign lsu_addr_incr_req_o = second_q;
    assign lsu_addr_last_o     = addr_last_q;
    assign busy_o              = ~idle;

endmodule
